// File: rtl/mig_app_bram_responder.sv
// BRAM-backed stand-in for the 7-series MIG app_* interface: in-order command queue,
// write-data FIFO, byte-masked block RAM and a fixed-latency read return pipeline.
module mig_app_bram_responder #(
   parameter int APP_ADDR_WIDTH = 28,
   parameter int APP_DATA_WIDTH = 256,
   parameter int ADDR_LSB       = 3,
   parameter int MEM_DEPTH_LOG2 = 10,
   parameter int QUEUE_DEPTH    = 4,
   parameter int RD_LATENCY     = 4,
   parameter int CALIB_CYCLES   = 64
) (
   input  logic                        ui_clk,
   input  logic                        resetn,
   output logic                        ui_clk_sync_rst,
   output logic                        init_calib_complete,
   input  logic [APP_ADDR_WIDTH-1:0]   app_addr,
   input  logic [2:0]                  app_cmd,
   input  logic                        app_en,
   output logic                        app_rdy,
   input  logic [APP_DATA_WIDTH-1:0]   app_wdf_data,
   input  logic [APP_DATA_WIDTH/8-1:0] app_wdf_mask,
   input  logic                        app_wdf_end,
   input  logic                        app_wdf_wren,
   output logic                        app_wdf_rdy,
   output logic [APP_DATA_WIDTH-1:0]   app_rd_data,
   output logic                        app_rd_data_end,
   output logic                        app_rd_data_valid,
   output logic                        cmd_err
);
   localparam int QW = $clog2(QUEUE_DEPTH);
   localparam int MW = APP_DATA_WIDTH / 8;
   localparam int CW = $clog2(CALIB_CYCLES + 1);
   localparam int DEPTH = 1 << MEM_DEPTH_LOG2;

   typedef enum logic {S_IDLE, S_EXEC} state_t;

   logic                      rst_meta_q, rst_sync_q;
   logic [CW-1:0]             cal_cnt_q;
   logic                      calib_q;
   state_t                    state_q, state_d;
   logic [QW:0]               cq_wr_q, cq_rd_q, cq_wr_d, cq_rd_d;
   logic [QW:0]               df_wr_q, df_rd_q, df_wr_d, df_rd_d;
   logic                      cq_rd_mem  [QUEUE_DEPTH];
   logic [MEM_DEPTH_LOG2-1:0] cq_idx_mem [QUEUE_DEPTH];
   logic [APP_DATA_WIDTH-1:0] df_data_mem [QUEUE_DEPTH];
   logic [MW-1:0]             df_mask_mem [QUEUE_DEPTH];
   logic [APP_DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [APP_DATA_WIDTH-1:0] rd_data_p0;
   logic [APP_DATA_WIDTH-1:0] rd_pipe_q [1:RD_LATENCY];
   logic [RD_LATENCY:0]       vld_q;
   logic                      cmd_err_q;

   logic cq_empty, cq_full, df_empty, df_full;
   logic cmd_acc, cmd_legal, cq_push, df_push;
   logic head_rd, exec_pop, wr_pop, rd_pop;
   logic [MEM_DEPTH_LOG2-1:0] addr_idx, head_idx;
   logic unused_addr;

   assign addr_idx    = app_addr[ADDR_LSB+MEM_DEPTH_LOG2-1:ADDR_LSB];
   assign unused_addr = ^{app_addr[APP_ADDR_WIDTH-1:ADDR_LSB+MEM_DEPTH_LOG2], app_addr[ADDR_LSB-1:0]};

   assign cq_empty = (cq_wr_q == cq_rd_q);
   assign cq_full  = (cq_wr_q[QW] != cq_rd_q[QW]) && (cq_wr_q[QW-1:0] == cq_rd_q[QW-1:0]);
   assign df_empty = (df_wr_q == df_rd_q);
   assign df_full  = (df_wr_q[QW] != df_rd_q[QW]) && (df_wr_q[QW-1:0] == df_rd_q[QW-1:0]);

   // Ready flags depend only on registered occupancy, never on the request strobes
   assign app_rdy     = calib_q & ~cq_full;
   assign app_wdf_rdy = calib_q & ~df_full;

   assign cmd_acc   = app_en & app_rdy;
   assign cmd_legal = (app_cmd[2:1] == 2'b00);
   assign cq_push   = cmd_acc & cmd_legal;
   assign df_push   = app_wdf_wren & app_wdf_rdy;

   assign head_rd  = cq_rd_mem[cq_rd_q[QW-1:0]];
   assign head_idx = cq_idx_mem[cq_rd_q[QW-1:0]];
   assign exec_pop = (state_q == S_EXEC) & ~cq_empty & (head_rd | ~df_empty);
   assign wr_pop   = exec_pop & ~head_rd;
   assign rd_pop   = exec_pop & head_rd;

   always_comb begin
      cq_wr_d = cq_wr_q + (QW+1)'(cq_push);
      cq_rd_d = cq_rd_q + (QW+1)'(exec_pop);
      df_wr_d = df_wr_q + (QW+1)'(df_push);
      df_rd_d = df_rd_q + (QW+1)'(wr_pop);
      state_d = (cq_wr_d != cq_rd_d) ? S_EXEC : S_IDLE;
   end

   always_ff @(posedge ui_clk or negedge resetn) begin
      if (!resetn) begin
         rst_meta_q <= 1'b1;
         rst_sync_q <= 1'b1;
      end else begin
         rst_meta_q <= 1'b0;
         rst_sync_q <= rst_meta_q;
      end
   end

   always_ff @(posedge ui_clk or negedge resetn) begin
      if (!resetn) begin
         cal_cnt_q <= '0;
         calib_q   <= 1'b0;
      end else if (!rst_sync_q && !calib_q) begin
         cal_cnt_q <= cal_cnt_q + 1'b1;
         if (cal_cnt_q == CW'(CALIB_CYCLES - 1)) calib_q <= 1'b1;
      end
   end

   always_ff @(posedge ui_clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= S_IDLE;
         cq_wr_q   <= '0;
         cq_rd_q   <= '0;
         df_wr_q   <= '0;
         df_rd_q   <= '0;
         cmd_err_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cq_wr_q <= cq_wr_d;
         cq_rd_q <= cq_rd_d;
         df_wr_q <= df_wr_d;
         df_rd_q <= df_rd_d;
         if ((cmd_acc && !cmd_legal) || (df_push && !app_wdf_end)) cmd_err_q <= 1'b1;
      end
   end

   always_ff @(posedge ui_clk) begin
      if (cq_push) begin
         cq_rd_mem[cq_wr_q[QW-1:0]]  <= app_cmd[0];
         cq_idx_mem[cq_wr_q[QW-1:0]] <= addr_idx;
      end
      if (df_push) begin
         df_data_mem[df_wr_q[QW-1:0]] <= app_wdf_data;
         df_mask_mem[df_wr_q[QW-1:0]] <= app_wdf_mask;
      end
   end

   // Block RAM: mask bit 1 keeps the stored byte
   always_ff @(posedge ui_clk) begin
      if (wr_pop) begin
         for (int b = 0; b < MW; b++) begin
            if (!df_mask_mem[df_rd_q[QW-1:0]][b])
               mem_q[head_idx][b*8 +: 8] <= df_data_mem[df_rd_q[QW-1:0]][b*8 +: 8];
         end
      end
      if (rd_pop) rd_data_p0 <= mem_q[head_idx];
   end

   always_ff @(posedge ui_clk or negedge resetn) begin
      if (!resetn) begin
         vld_q <= '0;
         for (int k = 1; k <= RD_LATENCY; k++) rd_pipe_q[k] <= '0;
      end else begin
         vld_q        <= {vld_q[RD_LATENCY-1:0], rd_pop};
         rd_pipe_q[1] <= rd_data_p0;
         for (int k = 2; k <= RD_LATENCY; k++) rd_pipe_q[k] <= rd_pipe_q[k-1];
      end
   end

   assign ui_clk_sync_rst     = rst_sync_q;
   assign init_calib_complete = calib_q;
   assign app_rd_data         = rd_pipe_q[RD_LATENCY];
   assign app_rd_data_valid   = vld_q[RD_LATENCY];
   assign app_rd_data_end     = vld_q[RD_LATENCY];
   assign cmd_err             = cmd_err_q;
endmodule

// File: tb/tb_mig_app_bram_responder.sv
// Directed bench for mig_app_bram_responder: reset/calibration, write/read round trips,
// masking, back-pressure, aliasing, illegal commands and reset with reads in flight.
module tb_mig_app_bram_responder;
   localparam int AW = 28;
   localparam int DW = 256;
   localparam int RDL = 4;
   localparam int CAL = 64;

   logic            ui_clk;
   logic            resetn;
   logic            ui_clk_sync_rst, init_calib_complete;
   logic [AW-1:0]   app_addr;
   logic [2:0]      app_cmd;
   logic            app_en, app_rdy;
   logic [DW-1:0]   app_wdf_data;
   logic [DW/8-1:0] app_wdf_mask;
   logic            app_wdf_end, app_wdf_wren, app_wdf_rdy;
   logic [DW-1:0]   app_rd_data;
   logic            app_rd_data_end, app_rd_data_valid, cmd_err;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc = 0;
   int vld_cnt = 0;
   logic [DW-1:0] rd_q [$];
   int            cyc_q [$];

   mig_app_bram_responder #(
      .APP_ADDR_WIDTH(AW), .APP_DATA_WIDTH(DW), .ADDR_LSB(3), .MEM_DEPTH_LOG2(10),
      .QUEUE_DEPTH(4), .RD_LATENCY(RDL), .CALIB_CYCLES(CAL)
   ) dut (
      .ui_clk(ui_clk), .resetn(resetn), .ui_clk_sync_rst(ui_clk_sync_rst),
      .init_calib_complete(init_calib_complete), .app_addr(app_addr), .app_cmd(app_cmd),
      .app_en(app_en), .app_rdy(app_rdy), .app_wdf_data(app_wdf_data),
      .app_wdf_mask(app_wdf_mask), .app_wdf_end(app_wdf_end), .app_wdf_wren(app_wdf_wren),
      .app_wdf_rdy(app_wdf_rdy), .app_rd_data(app_rd_data), .app_rd_data_end(app_rd_data_end),
      .app_rd_data_valid(app_rd_data_valid), .cmd_err(cmd_err)
   );

   initial ui_clk = 1'b0;
   always #5 ui_clk = ~ui_clk;

   always @(posedge ui_clk) begin
      cyc <= cyc + 1;
      if (app_rd_data_valid) begin
         vld_cnt <= vld_cnt + 1;
         rd_q.push_back(app_rd_data);
         cyc_q.push_back(cyc);
      end
   end

   task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge ui_clk);
      #1;
   endtask

   task automatic send_cmd(input logic [2:0] cmd, input logic [AW-1:0] addr);
      int n = 0;
      app_en = 1'b1; app_cmd = cmd; app_addr = addr;
      while (!app_rdy && n < 200) begin tick(); n++; end
      if (n >= 200) chk("cmd_rdy_timeout", 0, 1);
      tick();
      app_en = 1'b0;
   endtask

   task automatic send_data(input logic [DW-1:0] d, input logic [DW/8-1:0] m);
      int n = 0;
      app_wdf_wren = 1'b1; app_wdf_end = 1'b1; app_wdf_data = d; app_wdf_mask = m;
      while (!app_wdf_rdy && n < 200) begin tick(); n++; end
      if (n >= 200) chk("wdf_rdy_timeout", 0, 1);
      tick();
      app_wdf_wren = 1'b0; app_wdf_end = 1'b0;
   endtask

   task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] d, input logic [DW/8-1:0] m);
      int n = 0;
      app_en = 1'b1; app_cmd = 3'b000; app_addr = addr;
      app_wdf_wren = 1'b1; app_wdf_end = 1'b1; app_wdf_data = d; app_wdf_mask = m;
      while (!(app_rdy && app_wdf_rdy) && n < 200) begin tick(); n++; end
      if (n >= 200) chk("wr_rdy_timeout", 0, 1);
      tick();
      app_en = 1'b0; app_wdf_wren = 1'b0; app_wdf_end = 1'b0;
   endtask

   task automatic do_read(input string tag, input logic [AW-1:0] addr, input logic [DW-1:0] exp);
      int n = 0;
      send_cmd(3'b001, addr);
      while (!app_rd_data_valid && n < 30) begin tick(); n++; end
      chk({tag, "_lat"}, n, RDL + 1);
      chk({tag, "_data"}, app_rd_data, exp);
      chk({tag, "_end"}, app_rd_data_end, 1);
      tick();
      chk({tag, "_pulse"}, app_rd_data_valid, 0);
   endtask

   task automatic wait_calib();
      int n = 0;
      while (!init_calib_complete && n < 200) begin tick(); n++; end
      chk("calib_timeout", init_calib_complete, 1);
   endtask

   logic [DW-1:0] w0, d1, d7;
   logic [DW-1:0] dk [5];
   logic [DW/8-1:0] m_b0;
   int base;

   initial begin
      w0 = {32'hcafebabe, 32'h01234567, 32'h89abcdef, 32'hdeadbeef,
            32'h0badf00d, 32'h13579bdf, 32'h2468ace0, 32'haa55aa55};
      d1 = {8{32'h5a5a0001}};
      d7 = {8{32'h77007700}};
      for (int k = 0; k < 5; k++) dk[k] = {8{32'h10000000 + k}};
      m_b0 = 32'hFFFFFFFE;

      resetn = 1'b0; app_addr = '0; app_cmd = '0; app_en = 1'b0;
      app_wdf_data = '0; app_wdf_mask = '0; app_wdf_end = 1'b0; app_wdf_wren = 1'b0;
      tick(); tick(); tick();

      // reset values
      chk("rst_sync_rst", ui_clk_sync_rst, 1);
      chk("rst_calib", init_calib_complete, 0);
      chk("rst_rdy", app_rdy, 0);
      chk("rst_wdf_rdy", app_wdf_rdy, 0);
      chk("rst_rd_valid", app_rd_data_valid, 0);
      chk("rst_rd_end", app_rd_data_end, 0);
      chk("rst_rd_data", app_rd_data, 0);
      chk("rst_cmd_err", cmd_err, 0);

      // synchroniser and calibration timing
      resetn = 1'b1;
      tick();
      chk("sync_edge1", ui_clk_sync_rst, 1);
      tick();
      chk("sync_edge2", ui_clk_sync_rst, 0);
      for (int k = 0; k < CAL - 1; k++) tick();
      chk("calib_early", init_calib_complete, 0);
      chk("rdy_early", app_rdy, 0);
      tick();
      chk("calib_done", init_calib_complete, 1);
      chk("rdy_after_cal", app_rdy, 1);
      chk("wdf_rdy_after_cal", app_wdf_rdy, 1);

      // basic write then read
      do_write(28'h0, w0, '0);
      do_read("rd0", 28'h0, w0);

      // data leads its command by 3 cycles
      send_data(d1, '0);
      tick(); tick();
      send_cmd(3'b000, 28'd5 << 3);
      do_read("lead", 28'd5 << 3, d1);

      // byte mask over zero data
      do_write(28'd6 << 3, '0, '0);
      do_write(28'd6 << 3, {32{8'hA5}}, m_b0);
      do_read("mask", 28'd6 << 3, 256'hA5);

      // command queue back-pressure with no write data
      for (int k = 0; k < 4; k++) begin
         chk("stall_rdy", app_rdy, 1);
         send_cmd(3'b000, (28'd10 + k) << 3);
      end
      chk("full_rdy", app_rdy, 0);
      tick(); tick();
      chk("full_rdy_held", app_rdy, 0);
      send_data(dk[0], '0);
      send_cmd(3'b000, 28'd14 << 3);
      for (int k = 1; k < 5; k++) send_data(dk[k], '0);

      // back-to-back reads stream in order
      rd_q.delete(); cyc_q.delete();
      for (int k = 0; k < 5; k++) send_cmd(3'b001, (28'd10 + k) << 3);
      for (int k = 0; k < 10; k++) tick();
      chk("stream_count", rd_q.size(), 5);
      if (rd_q.size() == 5) begin
         base = cyc_q[0];
         for (int k = 0; k < 5; k++) begin
            chk($sformatf("stream_data%0d", k), rd_q[k], dk[k]);
            chk($sformatf("stream_cyc%0d", k), cyc_q[k], base + k);
         end
      end

      // aliasing and illegal command
      do_write(28'h1 << 13, d7, '0);
      do_read("alias", 28'h0, d7);
      base = vld_cnt;
      send_cmd(3'b010, 28'h0);
      tick();
      chk("cmd_err_set", cmd_err, 1);
      for (int k = 0; k < 10; k++) tick();
      chk("illegal_no_valid", vld_cnt, base);

      // reset with two reads in flight
      send_cmd(3'b001, 28'h0);
      send_cmd(3'b001, 28'd6 << 3);
      base = vld_cnt;
      resetn = 1'b0;
      #1;
      chk("midrst_cmd_err", cmd_err, 0);
      chk("midrst_sync", ui_clk_sync_rst, 1);
      chk("midrst_rdy", app_rdy, 0);
      tick(); tick();
      resetn = 1'b1;
      wait_calib();
      for (int k = 0; k < 5; k++) tick();
      chk("midrst_no_valid", vld_cnt, base);
      do_read("post_rst0", 28'h0, d7);
      do_read("post_rst6", 28'd6 << 3, 256'hA5);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: time %0t limit 200000", $time);
      $fatal(1, "timeout");
   end
endmodule
